vector_sequencer: RTL and testbench
===================================

# vector_sequencer

Command sequencer for the vector register file (`vrf`). It accepts one vector instruction at a time over a valid/ready interface and walks the instruction across `vlen_p/lanes_p` lane groups. For each group it drives the VRF read ports, runs the per-lane ALU and drives the VRF write port. Read results are returned as one full vector on a valid/yumi output. The block sits between the command source and `vrf` and is the only master of the VRF ports.

## Interface
Parameters:
- els_p, 32, number of vector registers
- vlen_p, 8, elements per vector; must be a multiple of lanes_p
- vdw_p, 8, bits per element
- lanes_p, 4, elements processed per cycle (group width)
- derived: G = vlen_p/lanes_p; v_addr_width_lp = clog2(els_p); grp_width_lp = safe_clog2(G)

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- reset_i  in  1  asynchronous reset, active-low.
- v_i  in  1  command valid.
- ready_o  out  1  command ready.
- op_i  in  4  opcode:
  - 0000 add, 0001 sub, 0010 mul (vector-vector)
  - 0100 add, 0101 sub, 0110 mul (vector-scalar)
  - 1000 read, 1001 write
- vd_i / vs1_i / vs2_i  in  v_addr_width_lp each  destination register and source registers.
- scalar_i  in  vdw_p  scalar operand.
- w_data_i  in  vlen_p*vdw_p  vector payload for write.
- r_data_o  out  vlen_p*vdw_p  vector read result.
- v_o  out  1  read result valid.
- yumi_i  in  1  consumer takes the read result.
- r0_addr_o / r1_addr_o  out  v_addr_width_lp+grp_width_lp  VRF read address = {reg, group}.
- r0_data_i / r1_data_i  in  lanes_p*vdw_p  VRF read data; returned 1 cycle after the address.
- w_addr_o  out  v_addr_width_lp+grp_width_lp  VRF write address.
- w_data_o  out  lanes_p*vdw_p  VRF write data.
- w_en_o  out  1  VRF write enable.

## Operation
- States:
  - IDLE
  - RUN: issue group reads
  - DRAIN: final write-back or capture
  - WRITE: write op only
  - RESP: read op only
- Command is accepted when v_i & ready_o. ready_o = (state==IDLE).
- At accept, latch op, vd, vs1, vs2, scalar and w_data. Clear group counter g to 0.
- Arithmetic ops:
  - RUN cycle k (k=0..G-1): r0_addr={vs1,k}, r1_addr={vs2,k}.
  - In the same cycle, for k≥1: w_en=1, w_addr={vd,k-1}, w_data=ALU(previous returned data).
  - RUN goes to DRAIN after k=G-1. DRAIN writes group G-1, then goes to IDLE.
- Vector-scalar ops replace operand B with scalar broadcast to all lanes; r1_addr is don't-care.
- ALU arithmetic is modulo 2^vdw_p, unsigned:
  - sub = A−B wrapped.
  - mul keeps the low vdw_p bits of the 2·vdw_p product.
- vd equal to vs1 or vs2 is legal. Group k is always read before it is written, so there is no hazard.
- Read op:
  - RUN issues r0_addr={vs1,k}.
  - Returned data for group k-1 is captured into result slice [k-1] (elements (k-1)·lanes_p…).
  - DRAIN captures group G-1, then goes to RESP.
- RESP: v_o=1 with r_data_o stable until yumi_i, then IDLE.
- Write op:
  - WRITE cycle k: w_en=1, w_addr={vd,k}, w_data = latched slice k.
  - Goes to IDLE after k=G-1.
- Any other opcode is accepted and dropped with no VRF access. The block stays in IDLE and ready_o remains 1.
- Reset values (async assert):
  - state=IDLE, g=0, ready_o=1 after release.
  - v_o=0, w_en_o=0, r_data_o=0.
  - All address outputs 0.
  - Reset mid-operation abandons the command. Writes already performed stay in the VRF.

## Timing
- Cycle numbering: accept edge = cycle 0. The first RUN/WRITE cycle is cycle 1.
- Arithmetic: busy G+1 cycles. The last write is at cycle G+1. ready_o=1 again at cycle G+2.
- Read: v_o rises at cycle G+2 and is held while !yumi_i. ready_o=1 the cycle after yumi_i.
- Write: G cycles of w_en. ready_o=1 at cycle G+1.
- w_en_o is 1 only in RUN (k≥1), DRAIN for arithmetic ops, and WRITE.
- yumi_i outside RESP is ignored. v_i while busy is ignored, with no latching.
- G=1 is legal: RUN lasts one cycle with no write, then DRAIN.

## Structure
- Shared package vector_pkg holds:
  - the opcode enum (op_add_e … op_write_e)
  - the state enum
  - helper predicates is_arith and is_scalar.
- Sub-module vector_lane_alu: combinational add/sub/mul of one vdw_p element, instantiated lanes_p times.
- The FSM, group counter, command latch and result buffer live in vector_sequencer.

## Test plan
All scenarios use the defaults (G=2).
- Write v3 with elements 1..8, then read v3:
  - w_en in cycles 1–2 with w_addr {3,0},{3,1}.
  - v_o at cycle 4, r_data_o = 1..8.
  - Holding yumi_i=0 for 3 cycles keeps data stable.
- v1=all 200, v2=all 100, op add vd=v4, then read v4 → every element 44 (300 mod 256). Sub v2−v1 → 156. Mul v1·v2 → 32 (20000 mod 256).
- Scalar mul: v1=all 3, scalar 5, op 0110 vd=v1 (in-place) → v1 all 15.
- Illegal opcode 0011 with v_i=1 → accepted, ready_o stays 1, no w_en for 5 cycles.
- Reset pulse (reset_i=0) at cycle 1 of an add:
  - w_en_o=0 and ready_o=1 after release.
  - The destination is unchanged; a subsequent read returns the old contents.
- Back-to-back commands with v_i held high: the second is accepted exactly at the first ready_o=1 cycle, and no command is accepted while busy.

Source files
------------

// File: rtl/vector_pkg.sv
// Shared opcode/state types and decode helpers for the vector sequencer
// and its per-lane ALU.
package vector_pkg;

  typedef enum logic [3:0] {
    op_add_e   = 4'b0000,
    op_sub_e   = 4'b0001,
    op_mul_e   = 4'b0010,
    op_adds_e  = 4'b0100,
    op_subs_e  = 4'b0101,
    op_muls_e  = 4'b0110,
    op_read_e  = 4'b1000,
    op_write_e = 4'b1001
  } op_e;

  typedef enum logic [1:0] {
    alu_add_e = 2'b00,
    alu_sub_e = 2'b01,
    alu_mul_e = 2'b10
  } alu_fn_e;

  typedef enum logic [2:0] {
    st_idle_e,
    st_run_e,
    st_drain_e,
    st_write_e,
    st_resp_e
  } state_e;

  function automatic logic is_arith(logic [3:0] op);
    return op inside {op_add_e, op_sub_e, op_mul_e, op_adds_e, op_subs_e, op_muls_e};
  endfunction

  function automatic logic is_scalar(logic [3:0] op);
    return op inside {op_adds_e, op_subs_e, op_muls_e};
  endfunction

  // The low two opcode bits select the ALU function for both operand forms.
  function automatic alu_fn_e alu_fn(logic [3:0] op);
    return alu_fn_e'(op[1:0]);
  endfunction

  // Keeps a 1-bit group field when there is only one group.
  function automatic int safe_clog2(int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vector_lane_alu.sv
// Combinational add/sub/mul of one element; all results wrap modulo 2^vdw_p.
module vector_lane_alu
  import vector_pkg::*;
#(
  parameter int vdw_p = 8
) (
  input  alu_fn_e            fn_i,
  input  logic [vdw_p-1:0]   a_i,
  input  logic [vdw_p-1:0]   b_i,
  output logic [vdw_p-1:0]   res_o
);

  always_comb begin
    // NOTE: assign a default first so every path drives res_o and no latch is inferred.
    res_o = a_i + b_i;
    case (fn_i)
      alu_sub_e: res_o = a_i - b_i;
      alu_mul_e: res_o = a_i * b_i;  // sized to vdw_p, so only the low product bits survive
      default:   ;
    endcase
  end

endmodule

// File: rtl/vector_sequencer.sv
// Walks one vector instruction across the VRF lane groups: issues reads,
// runs the lane ALUs, writes back, or collects a full vector for a read.
module vector_sequencer
  import vector_pkg::*;
#(
  parameter int  els_p           = 32,
  parameter int  vlen_p          = 8,
  parameter int  vdw_p           = 8,
  parameter int  lanes_p         = 4,
  localparam int grp_lp          = vlen_p / lanes_p,
  localparam int v_addr_width_lp = $clog2(els_p),
  localparam int grp_width_lp    = safe_clog2(grp_lp),
  localparam int addr_width_lp   = v_addr_width_lp + grp_width_lp
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       v_i,
  output logic                       ready_o,
  input  logic [3:0]                 op_i,
  input  logic [v_addr_width_lp-1:0] vd_i,
  input  logic [v_addr_width_lp-1:0] vs1_i,
  input  logic [v_addr_width_lp-1:0] vs2_i,
  input  logic [vdw_p-1:0]           scalar_i,
  input  logic [vlen_p*vdw_p-1:0]    w_data_i,
  output logic [vlen_p*vdw_p-1:0]    r_data_o,
  output logic                       v_o,
  input  logic                       yumi_i,
  output logic [addr_width_lp-1:0]   r0_addr_o,
  output logic [addr_width_lp-1:0]   r1_addr_o,
  input  logic [lanes_p*vdw_p-1:0]   r0_data_i,
  input  logic [lanes_p*vdw_p-1:0]   r1_data_i,
  output logic [addr_width_lp-1:0]   w_addr_o,
  output logic [lanes_p*vdw_p-1:0]   w_data_o,
  output logic                       w_en_o
);

  localparam logic [grp_width_lp-1:0] first_grp_lp = '0;
  localparam logic [grp_width_lp-1:0] last_grp_lp  = grp_width_lp'(grp_lp - 1);

  state_e                                state;
  logic [grp_width_lp-1:0]               g, g_next, g_prev;
  logic [3:0]                            op_q;
  logic [v_addr_width_lp-1:0]            vd_q, vs1_q, vs2_q;
  logic [vdw_p-1:0]                      scalar_q;
  logic [grp_lp-1:0][lanes_p*vdw_p-1:0]  w_buf, r_buf;
  logic [lanes_p-1:0][vdw_p-1:0]         a_lanes, b_lanes, alu_res;
  alu_fn_e                               fn;
  logic                                  accept;

  assign ready_o  = (state == st_idle_e);
  assign accept   = v_i & ready_o;
  assign r_data_o = r_buf;
  assign g_next   = g + grp_width_lp'(1);
  assign g_prev   = g - grp_width_lp'(1);

  // NOTE: the write payload is plain storage, always loaded at accept before
  // it is used, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (accept && op_i == op_write_e) w_buf <= w_data_i;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state     <= st_idle_e;
      g         <= '0;
      op_q      <= '0;
      vd_q      <= '0;
      vs1_q     <= '0;
      vs2_q     <= '0;
      scalar_q  <= '0;
      r_buf     <= '0;
      v_o       <= 1'b0;
      w_en_o    <= 1'b0;
      w_addr_o  <= '0;
      r0_addr_o <= '0;
      r1_addr_o <= '0;
    end else begin
      w_en_o <= 1'b0;
      case (state)
        st_idle_e: if (accept) begin
          op_q     <= op_i;
          vd_q     <= vd_i;
          vs1_q    <= vs1_i;
          vs2_q    <= vs2_i;
          scalar_q <= scalar_i;
          g        <= '0;
          if (is_arith(op_i) || op_i == op_read_e) begin
            state     <= st_run_e;
            r0_addr_o <= {vs1_i, first_grp_lp};
            r1_addr_o <= {vs2_i, first_grp_lp};
          end else if (op_i == op_write_e) begin
            state    <= st_write_e;
            w_en_o   <= 1'b1;
            w_addr_o <= {vd_i, first_grp_lp};
          end
        end
        st_run_e: begin
          // Data on the read ports belongs to the group addressed last cycle.
          if (op_q == op_read_e && g != first_grp_lp) r_buf[g_prev] <= r0_data_i;
          if (is_arith(op_q)) begin
            w_en_o   <= 1'b1;
            w_addr_o <= {vd_q, g};
          end
          if (g == last_grp_lp) begin
            state <= st_drain_e;
          end else begin
            g         <= g_next;
            r0_addr_o <= {vs1_q, g_next};
            r1_addr_o <= {vs2_q, g_next};
          end
        end
        st_drain_e: begin
          if (op_q == op_read_e) begin
            r_buf[last_grp_lp] <= r0_data_i;
            v_o                <= 1'b1;
            state              <= st_resp_e;
          end else begin
            state <= st_idle_e;
          end
        end
        st_write_e: begin
          if (g == last_grp_lp) begin
            state <= st_idle_e;
          end else begin
            g        <= g_next;
            w_en_o   <= 1'b1;
            w_addr_o <= {vd_q, g_next};
          end
        end
        st_resp_e: if (yumi_i) begin
          v_o   <= 1'b0;
          state <= st_idle_e;
        end
        default: state <= st_idle_e;
      endcase
    end
  end

  assign a_lanes = r0_data_i;
  assign fn      = alu_fn(op_q);

  always_comb begin
    b_lanes = r1_data_i;
    if (is_scalar(op_q)) b_lanes = {lanes_p{scalar_q}};
  end

  for (genvar i = 0; i < lanes_p; i++) begin : g_lane
    vector_lane_alu #(.vdw_p(vdw_p)) u_alu (
      .fn_i  (fn),
      .a_i   (a_lanes[i]),
      .b_i   (b_lanes[i]),
      .res_o (alu_res[i])
    );
  end

  // Write data is combinational so the ALU result lands in the cycle its operands return.
  always_comb begin
    w_data_o = alu_res;
    if (state == st_write_e) w_data_o = w_buf[g];
  end

endmodule

// File: tb/tb_vector_sequencer.sv
// Randomized scoreboard bench for vector_sequencer with a behavioural VRF
// and an element-level register model.
module tb_vector_sequencer;

  localparam int els_lp   = 32;
  localparam int vlen_lp  = 8;
  localparam int vdw_lp   = 8;
  localparam int lanes_lp = 4;
  localparam int grp_lp   = vlen_lp / lanes_lp;
  localparam int gw_lp    = (grp_lp > 1) ? $clog2(grp_lp) : 1;
  localparam int aw_lp    = $clog2(els_lp);
  localparam int lw_lp    = lanes_lp * vdw_lp;
  localparam int vw_lp    = vlen_lp * vdw_lp;
  localparam int mod_lp   = 1 << vdw_lp;

  typedef struct {
    logic [3:0]       op;
    int               vd, vs1, vs2;
    logic [vdw_lp-1:0] sc;
    logic [vw_lp-1:0] wd;
    int               stall;
  } cmd_t;

  typedef struct {
    int               cyc;
    int               addr;
    logic [lw_lp-1:0] data;
  } wr_t;

  typedef struct {
    logic [vw_lp-1:0] data;
    int               rise;
    int               stall;
  } rd_t;

  logic clk = 1'b0;
  logic reset_i = 1'b0;
  logic v_i = 1'b0, yumi_i = 1'b0;
  logic [3:0] op_i = '0;
  logic [aw_lp-1:0] vd_i = '0, vs1_i = '0, vs2_i = '0;
  logic [vdw_lp-1:0] scalar_i = '0;
  logic [vw_lp-1:0] w_data_i = '0;
  logic ready_o, v_o, w_en_o;
  logic [vw_lp-1:0] r_data_o;
  logic [aw_lp+gw_lp-1:0] r0_addr_o, r1_addr_o, w_addr_o;
  logic [lw_lp-1:0] r0_data_i, r1_data_i, w_data_o;

  vector_sequencer #(.els_p(els_lp), .vlen_p(vlen_lp), .vdw_p(vdw_lp), .lanes_p(lanes_lp)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o), .op_i(op_i),
    .vd_i(vd_i), .vs1_i(vs1_i), .vs2_i(vs2_i), .scalar_i(scalar_i), .w_data_i(w_data_i),
    .r_data_o(r_data_o), .v_o(v_o), .yumi_i(yumi_i),
    .r0_addr_o(r0_addr_o), .r1_addr_o(r1_addr_o), .r0_data_i(r0_data_i), .r1_data_i(r1_data_i),
    .w_addr_o(w_addr_o), .w_data_o(w_data_o), .w_en_o(w_en_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural VRF: one-cycle read latency, write on the clock edge.
  logic [lw_lp-1:0] mem [els_lp << gw_lp];
  logic [lw_lp-1:0] r0_q = '0, r1_q = '0;
  always @(posedge clk) begin
    if (w_en_o) mem[w_addr_o] <= w_data_o;
    r0_q <= mem[r0_addr_o];
    r1_q <= mem[r1_addr_o];
  end
  assign r0_data_i = r0_q;
  assign r1_data_i = r1_q;

  int n_checks = 0, n_errors = 0;
  int ref_v [els_lp][vlen_lp];
  wr_t exp_w[$];
  rd_t sb[$];
  int exp_ready = -1;
  int acc = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic cmd_t mk(input logic [3:0] op, input int vd, input int vs1, input int vs2,
                              input logic [vdw_lp-1:0] sc, input logic [vw_lp-1:0] wd, input int stall);
    cmd_t c;
    c.op = op; c.vd = vd; c.vs1 = vs1; c.vs2 = vs2; c.sc = sc; c.wd = wd; c.stall = stall;
    return c;
  endfunction

  function automatic logic [vw_lp-1:0] splat(input int v);
    logic [vw_lp-1:0] r;
    for (int e = 0; e < vlen_lp; e++) r[e*vdw_lp +: vdw_lp] = vdw_lp'(v);
    return r;
  endfunction

  function automatic logic [vw_lp-1:0] ref_vec(input int r);
    logic [vw_lp-1:0] d;
    for (int e = 0; e < vlen_lp; e++) d[e*vdw_lp +: vdw_lp] = vdw_lp'(ref_v[r][e]);
    return d;
  endfunction

  // Reference model: updates register contents and queues the expected VRF
  // writes / read response with the cycles at which they must appear.
  task automatic apply_model(input cmd_t c, input int a);
    int res [vlen_lp];
    int x, y;
    logic [vw_lp-1:0] v;
    wr_t w;
    rd_t r;
    case (c.op)
      4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6: begin
        for (int e = 0; e < vlen_lp; e++) begin
          x = ref_v[c.vs1][e];
          y = (c.op inside {4'h4, 4'h5, 4'h6}) ? int'(c.sc) : ref_v[c.vs2][e];
          if (c.op inside {4'h0, 4'h4})      res[e] = (x + y) % mod_lp;
          else if (c.op inside {4'h1, 4'h5}) res[e] = (x - y + mod_lp) % mod_lp;
          else                               res[e] = (x * y) % mod_lp;
        end
        for (int e = 0; e < vlen_lp; e++) ref_v[c.vd][e] = res[e];
        v = ref_vec(c.vd);
        for (int k = 0; k < grp_lp; k++) begin
          w.cyc = a + k + 2; w.addr = c.vd * (1 << gw_lp) + k; w.data = v[k*lw_lp +: lw_lp];
          exp_w.push_back(w);
        end
        exp_ready = a + grp_lp + 2;
      end
      4'h8: begin
        r.data = ref_vec(c.vs1); r.rise = a + grp_lp + 2; r.stall = c.stall;
        sb.push_back(r);
        exp_ready = -1;
      end
      4'h9: begin
        for (int e = 0; e < vlen_lp; e++) ref_v[c.vd][e] = int'(c.wd[e*vdw_lp +: vdw_lp]);
        for (int k = 0; k < grp_lp; k++) begin
          w.cyc = a + k + 1; w.addr = c.vd * (1 << gw_lp) + k; w.data = c.wd[k*lw_lp +: lw_lp];
          exp_w.push_back(w);
        end
        exp_ready = a + grp_lp + 1;
      end
      default: exp_ready = a + 1;
    endcase
  endtask

  task automatic send(input cmd_t c, input bit hold, input bit model);
    int waited = 0;
    @(negedge clk);
    while (!ready_o && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check(ready_o, "ready timeout", 64'(ready_o), 64'd1);
    if (exp_ready >= 0) check(cyc == exp_ready, "ready cycle", 64'(cyc), 64'(exp_ready));
    acc = cyc;
    op_i = c.op; vd_i = aw_lp'(c.vd); vs1_i = aw_lp'(c.vs1); vs2_i = aw_lp'(c.vs2);
    scalar_i = c.sc; w_data_i = c.wd; v_i = 1'b1;
    if (model) apply_model(c, acc);
    else exp_ready = -1;
    @(posedge clk);
    #1;
    if (!hold) v_i = 1'b0;
  endtask

  function automatic cmd_t rnd_cmd();
    logic [3:0] ops [10];
    ops = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'h3, 4'hb};
    return mk(ops[$urandom_range(0, 9)], $urandom_range(0, els_lp - 1), $urandom_range(0, els_lp - 1),
              $urandom_range(0, els_lp - 1), vdw_lp'($urandom), {$urandom, $urandom}, $urandom_range(0, 3));
  endfunction

  // Write monitor: every VRF write must match the next expected one.
  initial begin : wr_mon
    forever begin
      @(negedge clk);
      if (exp_w.size() > 0 && !(w_en_o && exp_w[0].cyc == cyc)) begin
        check(exp_w[0].cyc > cyc, "missed write", 64'(cyc), 64'(exp_w[0].cyc));
        if (exp_w[0].cyc <= cyc) void'(exp_w.pop_front());
      end
      if (w_en_o) begin
        check(exp_w.size() != 0, "unexpected w_en", 64'(w_addr_o), 64'd0);
        if (exp_w.size() != 0) begin
          check(cyc == exp_w[0].cyc, "write cycle", 64'(cyc), 64'(exp_w[0].cyc));
          check(int'(w_addr_o) == exp_w[0].addr, "write addr", 64'(w_addr_o), 64'(exp_w[0].addr));
          check(w_data_o == exp_w[0].data, "write data", 64'(w_data_o), 64'(exp_w[0].data));
          void'(exp_w.pop_front());
        end
      end
    end
  end

  // Read monitor: checks v_o timing, data stability while stalled, and the
  // return to ready after the consumer takes the result.
  initial begin : rd_mon
    int  stall_cnt = 0;
    bit  prev_v = 1'b0;
    bit  chk_ready = 1'b0;
    forever begin
      @(negedge clk);
      yumi_i = 1'b0;
      if (chk_ready) begin
        check(ready_o && !v_o, "ready after yumi", {62'd0, ready_o, v_o}, 64'd2);
        chk_ready = 1'b0;
      end
      if (!reset_i) begin
        prev_v = 1'b0;
        stall_cnt = 0;
      end else if (v_o) begin
        check(sb.size() != 0, "unexpected v_o", r_data_o, 64'd0);
        if (sb.size() != 0) begin
          if (!prev_v) check(cyc == sb[0].rise, "v_o rise cycle", 64'(cyc), 64'(sb[0].rise));
          check(r_data_o == sb[0].data, "r_data", r_data_o, sb[0].data);
          if (stall_cnt >= sb[0].stall) begin
            yumi_i = 1'b1;
            void'(sb.pop_front());
            stall_cnt = 0;
            chk_ready = 1'b1;
          end else begin
            stall_cnt++;
          end
        end
      end else begin
        yumi_i = 1'(($urandom_range(0, 1)));
      end
      prev_v = v_o;
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [vw_lp-1:0] seq;
    for (int r = 0; r < els_lp; r++)
      for (int e = 0; e < vlen_lp; e++) ref_v[r][e] = 0;

    repeat (3) @(negedge clk);
    check(v_o == 1'b0, "reset v_o", 64'(v_o), 64'd0);
    check(w_en_o == 1'b0, "reset w_en", 64'(w_en_o), 64'd0);
    check(r_data_o == '0, "reset r_data", r_data_o, 64'd0);
    check(r0_addr_o == '0 && r1_addr_o == '0 && w_addr_o == '0, "reset addr",
          64'({r0_addr_o, r1_addr_o, w_addr_o}), 64'd0);
    reset_i = 1'b1;
    #1;
    check(ready_o == 1'b1, "ready after reset", 64'(ready_o), 64'd1);

    for (int r = 0; r < els_lp; r++) send(mk(4'h9, r, 0, 0, '0, {$urandom, $urandom}, 0), 1'b0, 1'b1);

    // Write v3 = 1..8 then read it back with a three-cycle consumer stall.
    for (int e = 0; e < vlen_lp; e++) seq[e*vdw_lp +: vdw_lp] = vdw_lp'(e + 1);
    send(mk(4'h9, 3, 0, 0, '0, seq, 0), 1'b0, 1'b1);
    send(mk(4'h8, 0, 3, 0, '0, '0, 3), 1'b0, 1'b1);

    send(mk(4'h9, 1, 0, 0, '0, splat(200), 0), 1'b0, 1'b1);
    send(mk(4'h9, 2, 0, 0, '0, splat(100), 0), 1'b0, 1'b1);
    send(mk(4'h0, 4, 1, 2, '0, '0, 0), 1'b0, 1'b1);
    send(mk(4'h8, 0, 4, 0, '0, '0, 1), 1'b0, 1'b1);
    send(mk(4'h1, 5, 2, 1, '0, '0, 0), 1'b0, 1'b1);
    send(mk(4'h8, 0, 5, 0, '0, '0, 0), 1'b0, 1'b1);
    send(mk(4'h2, 6, 1, 2, '0, '0, 0), 1'b0, 1'b1);
    send(mk(4'h8, 0, 6, 0, '0, '0, 2), 1'b0, 1'b1);

    // In-place vector-scalar multiply.
    send(mk(4'h9, 1, 0, 0, '0, splat(3), 0), 1'b0, 1'b1);
    send(mk(4'h6, 1, 1, 0, 8'd5, '0, 0), 1'b0, 1'b1);
    send(mk(4'h8, 0, 1, 0, '0, '0, 0), 1'b0, 1'b1);

    // Illegal opcode is swallowed without any VRF traffic.
    send(mk(4'h3, 7, 7, 7, '0, '0, 0), 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check(ready_o && !w_en_o, "illegal op idle", {62'd0, ready_o, w_en_o}, 64'd2);
    end
    exp_ready = -1;

    // Reset in the first RUN cycle of an add abandons it.
    send(mk(4'h0, 4, 1, 2, '0, '0, 0), 1'b0, 1'b0);
    reset_i = 1'b0;
    @(negedge clk);
    reset_i = 1'b1;
    #1;
    check(w_en_o == 1'b0, "w_en after mid reset", 64'(w_en_o), 64'd0);
    check(ready_o == 1'b1, "ready after mid reset", 64'(ready_o), 64'd1);
    send(mk(4'h8, 0, 4, 0, '0, '0, 0), 1'b0, 1'b1);

    // Back-to-back random traffic with v_i held high between commands.
    for (int i = 0; i < 60; i++) send(rnd_cmd(), 1'b1, 1'b1);
    v_i = 1'b0;

    begin
      int waited = 0;
      while ((sb.size() != 0 || exp_w.size() != 0 || !ready_o) && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      check(sb.size() == 0 && exp_w.size() == 0, "drain", 64'(sb.size() + exp_w.size()), 64'd0);
    end
    @(posedge clk);
    #1;
    for (int r = 0; r < els_lp; r++) begin
      logic [vw_lp-1:0] got;
      for (int k = 0; k < grp_lp; k++) got[k*lw_lp +: lw_lp] = mem[r * (1 << gw_lp) + k];
      check(got == ref_vec(r), $sformatf("vrf v%0d", r), got, ref_vec(r));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
